// File: rtl/minv_host_if.sv
// Word-serial host front-end for the 256-bit modular-inversion engine: loads a/p, pulses minv_en, unloads result.
// Optional watchdog on the engine wait is enabled by defining MINV_TIMEOUT_EN.
module minv_host_if #(
   parameter int WORD_W      = 32,
   parameter int NWORDS      = 8,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WORD_W-1:0]        in_data,
   output logic [WORD_W*NWORDS-1:0] a_out,
   output logic [WORD_W*NWORDS-1:0] p_out,
   output logic                     minv_en,
   input  logic                     minv_rdy,
   input  logic [WORD_W*NWORDS-1:0] res_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WORD_W-1:0]        out_data,
   output logic                     out_last,
   output logic                     out_err,
   output logic                     busy
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_SEND  = 2'd3
   } state_e;

   if ((WORD_W * NWORDS != 256) || (NWORDS != 8) || (TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 65535)) begin : g_cfg_err
      $error("minv_host_if: unsupported parameter set");
   end

   state_e                     state_q;
   logic [3:0]                 wcnt_q;
   logic [WORD_W*NWORDS-1:0]   a_q;
   logic [WORD_W*NWORDS-1:0]   p_q;
   logic [WORD_W*NWORDS-1:0]   res_q;
   logic                       minv_en_q;
   logic [WORD_W-1:0]          out_data_q;
   logic                       out_last_q;
   logic                       busy_q;
   logic [2:0]                 widx_s;
   logic [2:0]                 nidx_s;

   assign widx_s = wcnt_q[2:0];
   assign nidx_s = wcnt_q[2:0] + 3'd1;

`ifdef MINV_TIMEOUT_EN
   localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);
   logic [15:0] wd_q;
   logic        err_q;
`endif

   // Load/start/wait/send sequencer; every output except the handshake decodes is a register here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_LOAD;
         wcnt_q     <= 4'd0;
         a_q        <= '0;
         p_q        <= '0;
         res_q      <= '0;
         minv_en_q  <= 1'b0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
         busy_q     <= 1'b0;
`ifdef MINV_TIMEOUT_EN
         wd_q       <= 16'd0;
         err_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (in_valid) begin
                  if (!wcnt_q[3]) begin
                     a_q[widx_s*WORD_W +: WORD_W] <= in_data;
                  end else begin
                     p_q[widx_s*WORD_W +: WORD_W] <= in_data;
                  end
                  if (wcnt_q == 4'd15) begin
                     state_q   <= ST_START;
                     wcnt_q    <= 4'd0;
                     minv_en_q <= 1'b1;
                     busy_q    <= 1'b1;
                  end else begin
                     wcnt_q <= wcnt_q + 4'd1;
                  end
               end
            end
            ST_START: begin
               minv_en_q <= 1'b0;
               state_q   <= ST_WAIT;
`ifdef MINV_TIMEOUT_EN
               wd_q      <= 16'd0;
`endif
            end
            ST_WAIT: begin
               // A ready arriving on the expiry cycle still wins over the watchdog.
               if (minv_rdy) begin
                  res_q      <= res_in;
                  out_data_q <= res_in[WORD_W-1:0];
                  out_last_q <= 1'b0;
                  state_q    <= ST_SEND;
`ifdef MINV_TIMEOUT_EN
                  err_q      <= 1'b0;
               end else if (wd_q == TMO_LIM) begin
                  res_q      <= '0;
                  out_data_q <= '0;
                  out_last_q <= 1'b0;
                  err_q      <= 1'b1;
                  state_q    <= ST_SEND;
               end else begin
                  wd_q <= wd_q + 16'd1;
`endif
               end
            end
            ST_SEND: begin
               if (out_ready) begin
                  if (widx_s == 3'd7) begin
                     state_q    <= ST_LOAD;
                     wcnt_q     <= 4'd0;
                     out_data_q <= '0;
                     out_last_q <= 1'b0;
                     busy_q     <= 1'b0;
`ifdef MINV_TIMEOUT_EN
                     err_q      <= 1'b0;
`endif
                  end else begin
                     wcnt_q     <= wcnt_q + 4'd1;
                     out_data_q <= res_q[nidx_s*WORD_W +: WORD_W];
                     out_last_q <= (nidx_s == 3'd7);
                  end
               end
            end
            default: begin
               state_q   <= ST_LOAD;
               wcnt_q    <= 4'd0;
               minv_en_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == ST_LOAD);
   assign out_valid = (state_q == ST_SEND);
   assign a_out     = a_q;
   assign p_out     = p_q;
   assign minv_en   = minv_en_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

`ifdef MINV_TIMEOUT_EN
   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

endmodule
